// File: rtl/spi_memory_burst_if.sv
// SPI pin bundle between an SPI master and the burst-memory slave.
interface spi_memory_burst_if;
    logic sclk_pin;
    logic cs_pin;
    logic mosi_pin;
    logic miso_pin;

    modport master (output sclk_pin, output cs_pin, output mosi_pin, input miso_pin);
    modport slave  (input sclk_pin, input cs_pin, input mosi_pin, output miso_pin);
endinterface

// File: rtl/spi_memory_burst.sv
// SPI mode-0 slave in front of a 2**ADDR_W x DATA_W memory with auto-incrementing bursts.
// All SPI pins are oversampled by clk; sclk must run at clk/8 or slower.
module spi_memory_burst #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 8,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    spi_memory_burst_if.slave spi,
    input  logic              fault_inject,
    output logic [DATA_W-1:0] leds,
    output logic              busy,
    output logic              frame_done
);
    localparam int CMD_W   = ADDR_W + 1;
    localparam int SHIFT_W = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int RX_W    = SHIFT_W - 1;
    localparam int CNT_W   = $clog2(SHIFT_W + 1);
    localparam int DEPTH   = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;
    state_t state, state_nxt;

    logic [2:0]        sclk_sh, cs_sh, mosi_sh;
    logic              sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_bit;
    logic              bit_in, bit_out;
    logic              cmd_done, wr_done, rd_done;
    logic [RX_W-1:0]   rx;
    logic [CMD_W-1:0]  cmd_word;
    logic [DATA_W-1:0] data_word, rd_word, tx;
    logic [CNT_W-1:0]  bit_cnt;
    logic [ADDR_W-1:0] addr;
    logic              miso_q, load_pending, reload;
    logic [DATA_W-1:0] mem [DEPTH];

    // Bits [1:0] are the two-flop synchroniser, bit [2] is the edge-detect history flop.
    assign sclk_rise = sclk_sh[1] & ~sclk_sh[2];
    assign sclk_fall = ~sclk_sh[1] & sclk_sh[2];
    assign cs_rise   = cs_sh[1] & ~cs_sh[2];
    assign cs_fall   = ~cs_sh[1] & cs_sh[2];
    assign mosi_bit  = mosi_sh[2];

    // A CS rising edge on the same clk as an sclk edge wins: the sclk edge is dropped.
    assign bit_in  = sclk_rise & ~cs_rise & (state != IDLE);
    assign bit_out = sclk_fall & ~cs_rise & (state == READ);

    assign cmd_word  = {rx[CMD_W-2:0], mosi_bit};
    assign data_word = {rx[DATA_W-2:0], mosi_bit};
    assign rd_word   = mem[addr];

    assign cmd_done = bit_in & (state == CMD)   & (bit_cnt == CNT_W'(CMD_W - 1));
    assign wr_done  = bit_in & (state == WRITE) & (bit_cnt == CNT_W'(DATA_W - 1));
    assign rd_done  = bit_in & (state == READ)  & (bit_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        // NOTE: hold-state default first so no path through this block infers a latch.
        state_nxt = state;
        if (cs_rise)                     state_nxt = IDLE;
        else if (state == IDLE && cs_fall) state_nxt = CMD;
        else if (cmd_done)               state_nxt = cmd_word[CMD_W-1] ? READ : WRITE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sh      <= '0;
            cs_sh        <= '0;
            mosi_sh      <= '0;
            rx           <= '0;
            tx           <= '0;
            bit_cnt      <= '0;
            addr         <= '0;
            miso_q       <= 1'b0;
            load_pending <= 1'b0;
            reload       <= 1'b0;
            leds         <= '0;
            frame_done   <= 1'b0;
        end else begin
            sclk_sh      <= {sclk_sh[1:0], spi.sclk_pin};
            cs_sh        <= {cs_sh[1:0], spi.cs_pin};
            mosi_sh      <= {mosi_sh[1:0], spi.mosi_pin};
            frame_done   <= cmd_done | wr_done | rd_done;
            load_pending <= 1'b0;
            if (cs_rise || (state == IDLE && cs_fall)) begin
                bit_cnt <= '0;
                reload  <= 1'b0;
                miso_q  <= 1'b0;
            end else begin
                if (bit_in) begin
                    rx      <= {rx[RX_W-2:0], mosi_bit};
                    bit_cnt <= (cmd_done | wr_done | rd_done) ? '0 : bit_cnt + 1'b1;
                end
                if (cmd_done) begin
                    addr         <= cmd_word[ADDR_W-1:0];
                    load_pending <= cmd_word[CMD_W-1];
                end
                if (wr_done || rd_done) addr <= addr + 1'b1;
                if (wr_done) leds <= data_word;
                if (rd_done) reload <= 1'b1;
                if (load_pending) tx <= rd_word;
                // The falling edge that closes a read frame fetches the next burst word.
                if (bit_out) begin
                    if (reload) begin
                        miso_q <= rd_word[DATA_W-1];
                        tx     <= {rd_word[DATA_W-2:0], 1'b0};
                        reload <= 1'b0;
                    end else begin
                        miso_q <= tx[DATA_W-1];
                        tx     <= {tx[DATA_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

    generate
        if (INIT_ZERO) begin : g_mem_clear
            // NOTE: resetting the array forces it into flops; the other branch leaves it RAM-inferable.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
                end else if (wr_done) begin
                    mem[addr] <= data_word;
                end
            end
        end else begin : g_mem_keep
            always_ff @(posedge clk) begin
                if (wr_done) mem[addr] <= data_word;
            end
        end
    endgenerate

    assign busy         = (state != IDLE);
    assign spi.miso_pin = (state == READ) & miso_q & ~fault_inject;

endmodule
